ps2_joy: RTL



---
 rtl/ps2_joy.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/ps2_joy.sv
// ps2_joy: PS/2 keyboard receiver and make/break decoder
// that drives the two NES gamepad button registers.
`timescale 1ns/1ps
module ps2_joy #(
  parameter int TIMEOUT = 25000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic [7:0] joy1,
  output logic [7:0] joy2,
  output logic [7:0] kb_code,
  output logic       kb_strobe
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    CHECK
  } state_t;

  state_t      state_q;
  logic [1:0]  clk_s_q;
  logic [1:0]  dat_s_q;
  logic        clk_prev_q;
  logic [7:0]  sr_q;
  logic        par_q;
  logic        stop_q;
  logic [3:0]  bit_q;
  logic [TW-1:0] to_q;
  logic        ext_q;
  logic        brk_q;
  logic [7:0]  joy1_q;
  logic [7:0]  joy2_q;
  logic [7:0]  code_q;
  logic        stb_q;

  logic        fall;
  logic        dat;
  logic        accept;
  logic [4:0]  lk;

  // {hit, player2, bit index} for an (ext, code) pair
  function automatic logic [4:0] lut(
    input logic       e,
    input logic [7:0] c
  );
    logic [4:0] r;
    r = 5'b0;
    case ({e, c})
      9'h01A: r = 5'b10_000;
      9'h022: r = 5'b10_001;
      9'h021: r = 5'b10_010;
      9'h05A: r = 5'b10_011;
      9'h175: r = 5'b10_100;
      9'h172: r = 5'b10_101;
      9'h16B: r = 5'b10_110;
      9'h174: r = 5'b10_111;
      9'h031: r = 5'b11_000;
      9'h03A: r = 5'b11_001;
      9'h02A: r = 5'b11_010;
      9'h029: r = 5'b11_011;
      9'h01D: r = 5'b11_100;
      9'h01B: r = 5'b11_101;
      9'h01C: r = 5'b11_110;
      9'h023: r = 5'b11_111;
      default: r = 5'b0;
    endcase
    return r;
  endfunction

  assign fall   = clk_prev_q & ~clk_s_q[1];
  assign dat    = dat_s_q[1];
  assign accept = (^{sr_q, par_q}) & stop_q;
  assign lk     = lut(ext_q, sr_q);

  assign joy1      = joy1_q;
  assign joy2      = joy2_q;
  assign kb_code   = code_q;
  assign kb_strobe = stb_q;

  // two-stage synchronizers plus previous-clock register for edge detect
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      clk_s_q    <= 2'b11;
      dat_s_q    <= 2'b11;
      clk_prev_q <= 1'b1;
    end else begin
      clk_s_q    <= {clk_s_q[0], ps2_clk};
      dat_s_q    <= {dat_s_q[0], ps2_dat};
      clk_prev_q <= clk_s_q[1];
    end
  end

  // receiver FSM, timeout, prefix tracking and button registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      sr_q    <= 8'h00;
      par_q   <= 1'b0;
      stop_q  <= 1'b0;
      bit_q   <= 4'd0;
      to_q    <= '0;
      ext_q   <= 1'b0;
      brk_q   <= 1'b0;
      joy1_q  <= 8'h00;
      joy2_q  <= 8'h00;
      code_q  <= 8'h00;
      stb_q   <= 1'b0;
    end else begin
      stb_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          to_q <= '0;
          if (fall && !dat) begin
            state_q <= SHIFT;
            bit_q   <= 4'd0;
          end
        end
        SHIFT: begin
          if (fall) begin
            to_q  <= '0;
            bit_q <= bit_q + 4'd1;
            if (bit_q < 4'd8) begin
              sr_q <= {dat, sr_q[7:1]};
            end else if (bit_q == 4'd8) begin
              par_q <= dat;
            end else begin
              stop_q  <= dat;
              state_q <= CHECK;
            end
          end else if (to_q == TW'(TIMEOUT)) begin
            state_q <= IDLE;
            to_q    <= '0;
            bit_q   <= 4'd0;
          end else begin
            to_q <= to_q + 1'b1;
          end
        end
        CHECK: begin
          state_q <= IDLE;
          bit_q   <= 4'd0;
          to_q    <= '0;
          if (accept) begin
            code_q <= sr_q;
            stb_q  <= 1'b1;
            if (sr_q == 8'hE0) begin
              ext_q <= 1'b1;
            end else if (sr_q == 8'hF0) begin
              brk_q <= 1'b1;
            end else begin
              ext_q <= 1'b0;
              brk_q <= 1'b0;
              if (lk[4]) begin
                if (lk[3]) joy2_q[lk[2:0]] <= ~brk_q;
                else       joy1_q[lk[2:0]] <= ~brk_q;
              end
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
